// File: rtl/sid_wq_pkg.sv
// Shared types and constants for the SID write queue.
//   DELAY_ADDR  : register address that marks a delay command (SID_WQ_DELAY_EN builds)
//   wq_state_e  : scheduler states
//   wq_entry_t  : one queued host write {addr, data}
package sid_wq_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] DELAY_ADDR = 5'h1F;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wq_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/sid_wq_fifo.sv
// Entry storage for the SID write queue: circular buffer with an explicit
// level counter, so full and empty are never confused when pointers meet.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push_i         : write wdata_i (dropped while full_o, or while flush_i)
//   pop_i          : remove head entry (ignored while empty_o, or while flush_i)
//   flush_i        : discard all entries next cycle; wins over push/pop
//   wdata_i        : entry to push
//   head_c_o       : current head entry (combinational read of storage)
//   level_o        : registered entry count
//   full_o/empty_o : registered level == DEPTH / level == 0
module sid_wq_fifo
  import sid_wq_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  wq_entry_t              wdata_i,
  output wq_entry_t              head_c_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  wq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  // Accept decisions use the registered flags, so a pop in the same cycle
  // never makes room for a push into a full buffer.
  always_comb begin
    push_ok  = push_i & ~full_q & ~flush_i;
    pop_ok   = pop_i & ~empty_q & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  // Pointers, level and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_W'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign level_o  = level_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;

endmodule

// File: rtl/sid_write_queue.sv
// SID write queue: buffers host register writes (12 MHz domain) and replays
// them to the SID at most one per 1 MHz clock-enable tick, in push order.
// Optional macro SID_WQ_DELAY_EN: entries addressed 5'h1F become delay
// commands that hold off the next pop for N further ticks (N = entry data).
// Ports:
//   clk, rst        : 12 MHz clock, synchronous active-high reset
//   iClkEn          : 1 MHz SID tick, one clk wide
//   iWE/iAddr/iDataW: host write strobe, register address, data
//   iFlush          : discard queued entries and any delay in progress
//   oWE/oAddr/oDataW: registered write strobe / address / data to the SID
//   oLevel, oFull   : registered queue occupancy and full flag
//   oOvf            : sticky flag, set when a push is dropped while full
module sid_write_queue
  import sid_wq_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iClkEn,
  input  logic                   iWE,
  input  logic [4:0]             iAddr,
  input  logic [7:0]             iDataW,
  input  logic                   iFlush,
  output logic                   oWE,
  output logic [4:0]             oAddr,
  output logic [7:0]             oDataW,
  output logic [$clog2(DEPTH):0] oLevel,
  output logic                   oFull,
  output logic                   oOvf
);

  wq_entry_t                push_entry;
  wq_entry_t                head;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop_c;

  logic                     we_q, we_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     ovf_q, ovf_d;

`ifdef SID_WQ_DELAY_EN
  wq_state_e                state_q, state_d;
  logic [DATA_W-1:0]        cnt_q, cnt_d;
`endif

  assign push_entry = '{addr: iAddr, data: iDataW};

  sid_wq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (iWE),
    .pop_i    (pop_c),
    .flush_i  (iFlush),
    .wdata_i  (push_entry),
    .head_c_o (head),
    .level_o  (fifo_level),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Scheduler: decides the pop and the next output/state values.
  always_comb begin
    pop_c  = 1'b0;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    ovf_d  = ovf_q | (iWE & fifo_full);
`ifdef SID_WQ_DELAY_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    if (iFlush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (iClkEn) begin
      // A running delay consumes ticks until its count reaches zero; the
      // tick that finds zero behaves exactly like IDLE.
      if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_d = cnt_q - 8'd1;
      end else if (!fifo_empty) begin
        pop_c = 1'b1;
        if (head.addr == DELAY_ADDR) begin
          state_d = WAIT;
          cnt_d   = head.data;
        end else begin
          state_d = IDLE;
          we_d    = 1'b1;
          addr_d  = head.addr;
          data_d  = head.data;
        end
      end else begin
        state_d = IDLE;
      end
    end
`else
    if (!iFlush && iClkEn && !fifo_empty) begin
      pop_c  = 1'b1;
      we_d   = 1'b1;
      addr_d = head.addr;
      data_d = head.data;
    end
`endif
  end

`ifdef SID_WQ_DELAY_EN
  // Scheduler state and delay counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  // Output registers; address and data hold between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign oWE    = we_q;
  assign oAddr  = addr_q;
  assign oDataW = data_q;
  assign oLevel = fifo_level;
  assign oFull  = fifo_full;
  assign oOvf   = ovf_q;

endmodule

// File: tb/tb_sid_write_queue.sv
// Self-checking bench for sid_write_queue: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_sid_write_queue;

  localparam int unsigned DEPTH = 16;
`ifdef SID_WQ_DELAY_EN
  localparam bit DELAY_ON = 1'b1;
`else
  localparam bit DELAY_ON = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   iClkEn;
  logic                   iWE;
  logic [4:0]             iAddr;
  logic [7:0]             iDataW;
  logic                   iFlush;
  logic                   oWE;
  logic [4:0]             oAddr;
  logic [7:0]             oDataW;
  logic [$clog2(DEPTH):0] oLevel;
  logic                   oFull;
  logic                   oOvf;

  sid_write_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .iClkEn (iClkEn),
    .iWE    (iWE),
    .iAddr  (iAddr),
    .iDataW (iDataW),
    .iFlush (iFlush),
    .oWE    (oWE),
    .oAddr  (oAddr),
    .oDataW (oDataW),
    .oLevel (oLevel),
    .oFull  (oFull),
    .oOvf   (oOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued writes plus number of ticks still to be skipped.
  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       mq[$];
  int         m_skip;
  bit         m_we;
  logic [4:0] m_addr;
  logic [7:0] m_data;
  bit         m_ovf;

  int vectors;
  int miscompares;
  int we_pulses;

  function automatic void model_reset();
    mq.delete();
    m_skip = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_apply(input bit we, input logic [4:0] a,
                                      input logic [7:0] d, input bit ce, input bit fl);
    int   pre;
    ent_t e;
    pre  = mq.size();
    m_we = 1'b0;
    if (we && pre == DEPTH) m_ovf = 1'b1;
    if (fl) begin
      mq.delete();
      m_skip = 0;
    end else begin
      if (ce) begin
        if (m_skip > 0) begin
          m_skip--;
        end else if (pre > 0) begin
          e = mq.pop_front();
          if (DELAY_ON && e.a == 5'h1F) begin
            m_skip = int'(e.d);
          end else begin
            m_we   = 1'b1;
            m_addr = e.a;
            m_data = e.d;
          end
        end
      end
      if (we && pre < DEPTH) begin
        e.a = a;
        e.d = d;
        mq.push_back(e);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("oWE",    32'(oWE),    32'(m_we));
    chk("oAddr",  32'(oAddr),  32'(m_addr));
    chk("oDataW", 32'(oDataW), 32'(m_data));
    chk("oLevel", 32'(oLevel), 32'(mq.size()));
    chk("oFull",  32'(oFull),  32'(mq.size() == DEPTH));
    chk("oOvf",   32'(oOvf),   32'(m_ovf));
  endtask

  // One clock cycle with the given inputs, then model update and checks.
  task automatic step(input bit we, input logic [4:0] a, input logic [7:0] d,
                      input bit ce, input bit fl, input bit r);
    iWE    = we;
    iAddr  = a;
    iDataW = d;
    iClkEn = ce;
    iFlush = fl;
    rst    = r;
    @(posedge clk);
    if (r) model_reset();
    else   model_apply(we, a, d, ce, fl);
    #1;
    if (oWE === 1'b1) we_pulses++;
    check_all();
  endtask

  task automatic push(input logic [4:0] a, input logic [7:0] d);
    step(1'b1, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'h0, 8'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 5'h0, 8'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bit         r_we, r_ce, r_fl, r_rst;
    logic [4:0] r_a;
    logic [7:0] r_d;
    bit         ovf_before;

    vectors     = 0;
    miscompares = 0;
    we_pulses   = 0;
    model_reset();
    iWE = 1'b0; iAddr = '0; iDataW = '0; iClkEn = 1'b0; iFlush = 1'b0; rst = 1'b1;

    // Reset state.
    step(1'b0, 5'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Three pushes, drained on three ticks in order.
    push(5'h00, 8'h11);
    push(5'h01, 8'h22);
    push(5'h18, 8'h0F);
    chk("three_level", 32'(oLevel), 32'd3);
    we_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      idle(11);
      tick();
    end
    idle(1);
    chk("three_pulses", 32'(we_pulses), 32'd3);
    chk("three_empty",  32'(oLevel),    32'd0);

    // Overflow: 17 pushes without ticks.
    for (int i = 0; i < 17; i++) push(5'(i), 8'(8'h40 + i));
    chk("ovf_level", 32'(oLevel), 32'd16);
    chk("ovf_full",  32'(oFull),  32'd1);
    chk("ovf_flag",  32'(oOvf),   32'd1);
    // Push while full with a simultaneous pop must still be dropped.
    step(1'b1, 5'h1E, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk("ovf_pop_level", 32'(oLevel), 32'd15);
    we_pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      idle(1);
    end
    chk("ovf_pulses", 32'(we_pulses), 32'd15);
    chk("ovf_drained", 32'(oLevel), 32'd0);

    // Push into empty FIFO on a tick: issued only after the next tick.
    step(1'b1, 5'h02, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("same_tick_owe", 32'(oWE), 32'd0);
    idle(5);
    tick();
    chk("next_tick_owe",  32'(oWE),    32'd1);
    chk("next_tick_data", 32'(oDataW), 32'h55);

    // Flush with five queued entries (a delay in progress when enabled).
    if (DELAY_ON) push(5'h1F, 8'h0A);
    else          push(5'h04, 8'h01);
    for (int i = 0; i < 4; i++) push(5'(5 + i), 8'(8'hC0 + i));
    tick();
    idle(2);
    tick();
    ovf_before = m_ovf;
    step(1'b0, 5'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    chk("flush_level", 32'(oLevel), 32'd0);
    chk("flush_ovf",   32'(oOvf),   32'(ovf_before));
    we_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      idle(2);
      tick();
    end
    chk("flush_no_owe", 32'(we_pulses), 32'd0);

    // Reset mid-queue while the overflow flag is set.
    push(5'h0A, 8'h01);
    push(5'h0B, 8'h02);
    tick();
    step(1'b0, 5'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_owe",   32'(oWE),    32'd0);
    chk("rst_addr",  32'(oAddr),  32'd0);
    chk("rst_data",  32'(oDataW), 32'd0);
    chk("rst_level", 32'(oLevel), 32'd0);
    chk("rst_ovf",   32'(oOvf),   32'd0);
    push(5'h03, 8'h77);
    idle(2);
    tick();
    chk("rst_after_owe",  32'(oWE),    32'd1);
    chk("rst_after_addr", 32'(oAddr),  32'h03);
    chk("rst_after_data", 32'(oDataW), 32'h77);

`ifdef SID_WQ_DELAY_EN
    // Delay entry: AA at tick 0, delay at tick 1, BB at tick 5.
    idle(2);
    push(5'h00, 8'hAA);
    push(5'h1F, 8'h03);
    push(5'h01, 8'hBB);
    for (int t = 0; t < 8; t++) begin
      idle(2);
      tick();
      chk("delay_owe", 32'(oWE), (t == 0 || t == 5) ? 32'd1 : 32'd0);
      if (t == 5) chk("delay_bb", 32'(oDataW), 32'hBB);
    end
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r_we  = ($urandom_range(0, 2) == 0);
      r_a   = 5'($urandom);
      r_d   = (DELAY_ON && r_a == 5'h1F) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      r_ce  = ($urandom_range(0, 3) == 0);
      r_fl  = ($urandom_range(0, 149) == 0);
      r_rst = ($urandom_range(0, 399) == 0);
      step(r_we, r_a, r_d, r_ce, r_fl, r_rst);
    end
    for (int i = 0; i < 80; i++) begin
      idle(1);
      tick();
    end
    chk("final_level", 32'(oLevel), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sid_write_queue.md
SID_WRITE_QUEUE -- requirements
Module: sid_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  system clock, 12 MHz; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port iClkEn  input  1  1 MHz SID clock enable, one clk cycle wide.
REQ-005 SHALL have port iWE  input  1  host write strobe, one clk cycle per write.
REQ-006 SHALL have port iAddr  input  5  host SID register address.
REQ-007 SHALL have port iDataW  input  8  host write data.
REQ-008 SHALL have port iFlush  input  1  discard queued writes and any wait in progress.
REQ-009 SHALL have port oWE  output  1  write strobe to SID.
REQ-010 SHALL have port oAddr  output  5  SID register address.
REQ-011 SHALL have port oDataW  output  8  SID write data.
REQ-012 SHALL have port oLevel  output  $clog2(DEPTH)+1  current entry count.
REQ-013 SHALL have port oFull  output  1  oLevel == DEPTH.
REQ-014 SHALL have port oOvf  output  1  sticky flag, set when a push is dropped.

Function
REQ-015 SHALL push {iAddr,iDataW} on each clk cycle with iWE=1 and oFull=0, as registered at the start of that cycle.
REQ-016 SHALL drop a push while oFull=1, even if a pop occurs in the same cycle, and SHALL set oOvf.
REQ-017 SHALL pop at most one entry per iClkEn pulse, and only when the FIFO is non-empty and the state permits it.
REQ-018 SHALL use states IDLE and WAIT; WAIT exists only under the Configuration macro.
REQ-019 IDLE: on a cycle with iClkEn=1 and the FIFO non-empty, SHALL pop the head entry. For a normal entry it SHALL stay in IDLE.
REQ-020 For a popped normal entry, SHALL drive oWE=1 for exactly one clk cycle, the cycle after the pop. oAddr and oDataW SHALL be valid in that cycle and hold until the next issue.
REQ-021 Ordering: oWE SHALL follow the exact push order, with no reordering and no merging.
REQ-022 A push and a pop in the same cycle SHALL leave oLevel unchanged.
REQ-023 A push into an empty FIFO on an iClkEn cycle SHALL NOT be popped in that cycle. The earliest pop is the next iClkEn.
REQ-024 oLevel and oFull SHALL be registered, reflecting the pushes and pops of the previous cycle.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; a full/empty ambiguity SHALL NOT occur.
REQ-026 iFlush=1 SHALL, next cycle, set oLevel=0, state IDLE and oWE=0.
REQ-027 iFlush SHALL have priority over a simultaneous push and pop; a push in the flush cycle is discarded.
REQ-028 iFlush SHALL NOT clear oOvf.

Reset
REQ-029 On rst=1 at a clk edge, the block SHALL set oWE=0, oAddr=0, oDataW=0, oLevel=0, oFull=0, oOvf=0, state IDLE and delay counter 0.
REQ-030 rst SHALL have priority over iFlush, iWE and iClkEn.
REQ-031 rst SHALL abort any wait or issue in progress; queued entries are lost.

Configuration
REQ-032 Macro SID_WQ_DELAY_EN SHALL enable delay entries.
REQ-033 With SID_WQ_DELAY_EN defined, a popped entry with addr 5'h1F is a delay command. It SHALL produce no oWE, SHALL load an 8-bit counter with its data N, and SHALL enter WAIT.
REQ-034 With SID_WQ_DELAY_EN defined, in WAIT on each iClkEn: if the counter is 0, the block SHALL behave as IDLE (pop allowed, state becomes IDLE or reloads WAIT); otherwise it SHALL decrement the counter without popping.
REQ-035 With SID_WQ_DELAY_EN defined, a delay popped on tick T SHALL give the next pop at tick T+N+1; N=0 SHALL give T+1.
REQ-036 With SID_WQ_DELAY_EN undefined, addr 5'h1F SHALL be a normal write, and no WAIT state or counter SHALL be synthesized.

Structure
REQ-037 A shared package sid_wq_pkg SHALL hold: DELAY_ADDR = 5'h1F, the state enum {IDLE, WAIT}, and the entry struct {addr[4:0], data[7:0]}.
REQ-038 The design SHALL contain one sub-module, sid_wq_fifo: storage, pointers, level, full/empty, flush; single clock.
REQ-039 Scheduler FSM, delay counter and output registers SHALL live in sid_write_queue.

Verification
REQ-040 Three pushes (00,11),(01,22),(18,0F) within 3 clk cycles -> three oWE pulses on consecutive iClkEn ticks, in order; oLevel 3->0.
REQ-041 DEPTH=16: 17 pushes with no iClkEn -> oLevel=16, oFull=1, oOvf=1, 17th entry absent from the output.
REQ-042 Push on the same cycle as iClkEn with the FIFO empty -> no oWE on that tick; oWE one cycle after the next tick.
REQ-043 SID_WQ_DELAY_EN: push (00,AA),(1F,03),(01,BB) -> write AA at tick T, delay popped at T+1, write BB popped at T+5, no oWE for the delay entry.
REQ-044 Five entries queued, iFlush during a delay wait -> oLevel=0 next cycle, no further oWE, oOvf unchanged.
REQ-045 rst asserted for 1 cycle mid-queue with oOvf=1 -> all outputs 0 next cycle; a new push is issued normally afterwards.
